// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-save packet accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_ISSUE,
        ST_DRAIN,
        ST_OUTPUT
    } state_e;

    localparam int MAX_BEATS = 255;
    localparam int GROUP_SZ  = 6;
    localparam int SUM_W     = 7;

    // 3:2 compressor on 7-bit vectors; returns {sum, carry} with carry pre-shifted.
    function automatic logic [13:0] csa3(input logic [6:0] a, input logic [6:0] b,
                                         input logic [6:0] c);
        logic [6:0] maj;
        maj = (a & b) | (a & c) | (b & c);
        return {a ^ b ^ c, maj[5:0], 1'b0};
    endfunction

endpackage

// File: rtl/csa6_pipe.sv
// Six-operand carry-save adder tree with a final carry-propagate add, LAT clocks deep.
module csa6_pipe
    import csa_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue_i,
    input  logic [23:0] ops_i,
    output logic [6:0]  sum_o
);

    logic [6:0] op [GROUP_SZ];
    logic [6:0] s1, c1, s2, c2, s3, c3, s4, c4;
    logic [6:0] sum_q;

    // Idle cycles feed zeros so the pipe never carries stale operands.
    always_comb begin
        for (int i = 0; i < GROUP_SZ; i++) begin
            op[i] = issue_i ? {3'b000, ops_i[4*i +: 4]} : 7'd0;
        end
    end

    assign {s1, c1} = csa3(op[0], op[1], op[2]);
    assign {s2, c2} = csa3(op[3], op[4], op[5]);
    assign {s3, c3} = csa3(s1, c1, s2);
    assign {s4, c4} = csa3(s3, c3, c2);

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) sum_q <= '0;
                else          sum_q <= s4 + c4;
            end
        end else begin : g_multi
            logic [6:0] s_q [LAT-1];
            logic [6:0] c_q [LAT-1];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int k = 0; k < LAT-1; k++) begin
                        s_q[k] <= '0;
                        c_q[k] <= '0;
                    end
                    sum_q <= '0;
                end else begin
                    s_q[0] <= s4;
                    c_q[0] <= c4;
                    for (int k = 1; k < LAT-1; k++) begin
                        s_q[k] <= s_q[k-1];
                        c_q[k] <= c_q[k-1];
                    end
                    sum_q <= s_q[LAT-2] + c_q[LAT-2];
                end
            end
        end
    endgenerate

    assign sum_o = sum_q;

endmodule

// File: rtl/csa_accum_ctrl.sv
// Packet accumulator: gathers 4-bit beats into groups of six, sums each group in
// csa6_pipe and accumulates group results into a per-packet total.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_COLLECT | accepting beats into operand slots
// ST_ISSUE   | group handed to csa6_pipe for one cycle, slots cleared
// ST_DRAIN   | packet closed, waiting for in-flight groups to accumulate
// ST_OUTPUT  | result held until out_ready handshake
module csa_accum_ctrl
    import csa_pkg::*;
#(
    parameter int LAT   = 3,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count,
    output logic             out_err,
    output logic             busy
);

    state_e          state_q;
    logic [5:0][3:0] slot_q;
    logic [2:0]      slot_cnt_q;
    logic [7:0]      cnt_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic            err_q, close_q, out_valid_q;
    logic [LAT-1:0]  inflight_q;
    logic [6:0]      grp_sum;
    logic            issue, accept, grp_full, at_limit;

    assign issue    = (state_q == ST_ISSUE);
    assign in_ready = (state_q == ST_COLLECT);
    assign accept   = in_valid && in_ready;
    assign grp_full = (slot_cnt_q == 3'(GROUP_SZ - 1));
    assign at_limit = (cnt_q == 8'(MAX_BEATS - 1));

    // Results land whenever their valid bit leaves the tracker, whatever the state.
    assign acc_d = inflight_q[LAT-1] ? acc_q + ACC_W'(grp_sum) : acc_q;

    csa6_pipe #(.LAT(LAT)) u_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .issue_i (issue),
        .ops_i   (slot_q),
        .sum_o   (grp_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_COLLECT;
            slot_q      <= '0;
            slot_cnt_q  <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
            close_q     <= 1'b0;
            out_valid_q <= 1'b0;
            inflight_q  <= '0;
        end else begin
            inflight_q <= (inflight_q << 1) | LAT'(issue);
            acc_q      <= acc_d;
            case (state_q)
                ST_COLLECT: begin
                    if (accept) begin
                        slot_q[slot_cnt_q] <= in_data;
                        slot_cnt_q         <= slot_cnt_q + 3'd1;
                        cnt_q              <= cnt_q + 8'd1;
                        if (grp_full || in_last || at_limit) begin
                            state_q <= ST_ISSUE;
                            close_q <= in_last || at_limit;
                            err_q   <= at_limit && !in_last;
                        end
                    end
                end
                ST_ISSUE: begin
                    slot_q     <= '0;
                    slot_cnt_q <= '0;
                    state_q    <= close_q ? ST_DRAIN : ST_COLLECT;
                end
                ST_DRAIN: begin
                    if (inflight_q == '0) begin
                        state_q     <= ST_OUTPUT;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        state_q     <= ST_COLLECT;
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        close_q     <= 1'b0;
                    end
                end
                default: state_q <= ST_COLLECT;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_count = cnt_q;
    assign out_err   = err_q;
    assign busy      = !((state_q == ST_COLLECT) && (slot_cnt_q == '0) && (inflight_q == '0));

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl against a packet-level arithmetic model.
module tb_csa_accum_ctrl;

    localparam int LAT   = 3;
    localparam int ACC_W = 12;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid, in_last, in_ready;
    logic [3:0]       in_data;
    logic             out_valid, out_ready, out_err, busy;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int beats[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    csa_accum_ctrl #(.LAT(LAT), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_err   (out_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drives the packet in 'beats' and checks the result; model is plain arithmetic.
    task automatic run_packet(input bit use_last, input int hold, input bit gaps);
        int exp_sum = 0;
        int exp_cnt = 0;
        int first_acc = 0;
        int last_acc = 0;
        int waited;
        bit exp_err;
        bit stable;
        foreach (beats[i]) begin
            if (exp_cnt < 255) begin
                exp_sum += beats[i];
                exp_cnt++;
            end
        end
        exp_err = (exp_cnt == 255) && !(use_last && beats.size() == 255);

        for (int i = 0; i < exp_cnt; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = 4'(beats[i]);
            in_last  = use_last && (i == beats.size() - 1);
            waited = 0;
            while (!in_ready && waited < 100) begin @(posedge clk); #1; waited++; end
            if (!in_ready) begin
                check("accept_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (i == 0) first_acc = cyc;
            last_acc = cyc;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
        if (!gaps) check("throughput", last_acc - first_acc, (exp_cnt - 1) + (exp_cnt - 1) / 6);

        waited = 0;
        while (!out_valid && waited < 60) begin @(posedge clk); #1; waited++; end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        check("latency", cyc - last_acc, LAT + 2);
        check("out_sum", out_sum, exp_sum);
        check("out_count", out_count, exp_cnt);
        check("out_err", out_err, exp_err);

        stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || out_sum != exp_sum || out_count != exp_cnt ||
                out_err != exp_err || in_ready) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", stable, 1);

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_hs_valid", out_valid, 0);
        check("post_hs_ready", in_ready, 1);
        check("post_hs_busy", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_err", out_err, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        beats = {15, 15, 15, 15, 15, 15};
        run_packet(1'b1, 0, 1'b0);

        beats = {1, 1, 1, 1, 1, 1, 1};
        run_packet(1'b1, 0, 1'b0);

        beats = {0};
        run_packet(1'b1, 0, 1'b0);

        beats = {2, 9, 4};
        run_packet(1'b1, 10, 1'b0);
        beats = {6, 1};
        run_packet(1'b1, 0, 1'b0);

        beats.delete();
        for (int i = 0; i < 255; i++) beats.push_back(15);
        run_packet(1'b0, 2, 1'b0);

        // Reset while draining: partial result must vanish.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 4'd5;
            in_last  = (i == 2);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("drain_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_stale_result", seen, 0);
        beats = {3, 4};
        run_packet(1'b1, 0, 1'b0);

        for (int p = 0; p < 10; p++) begin
            int n;
            n = $urandom_range(1, 20);
            beats.delete();
            for (int i = 0; i < n; i++) beats.push_back($urandom_range(0, 15));
            run_packet(1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
